// File: rtl/ins_fetch_if.sv
// Fetch-stage bus: instruction-memory port, control-unit inputs and decoder handshake.
// Latency: none, this is wiring only.
// Backpressure: the decoder stalls the stage by holding dec_ready low.
interface ins_fetch_if;
    // instruction memory
    logic [31:0] Ins;
    logic [31:0] pc;
    logic        InsMemRW;
    // control unit / register file
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic [31:0] imm_ext;
    logic [31:0] rs_data;
    // decoder handshake
    logic        dec_ready;
    logic [31:0] ir;
    logic        ir_valid;
    // status
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    // The fetch stage itself
    modport master (
        input  Ins, PCWre, PCSrc, imm_ext, rs_data, dec_ready,
        output pc, InsMemRW, ir, ir_valid, halted, fault, fetch_count
    );

    // Memory, control unit and decoder side
    modport slave (
        output Ins, PCWre, PCSrc, imm_ext, rs_data, dec_ready,
        input  pc, InsMemRW, ir, ir_valid, halted, fault, fetch_count
    );
endinterface

// File: rtl/ins_fetch.sv
// Instruction fetch: owns pc, reads instruction memory, offers ir to the decoder.
// Latency: 2 cycles per instruction minimum (FETCH then VALID); first ir two edges after reset release.
// Backpressure: ir/pc hold in VALID until dec_ready and PCWre are both high on an edge.
// Optional feature: FETCH_STATS_EN enables the fetch_count counter (tied to 0 otherwise).
module ins_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 128
) (
    input  logic       CLK,
    input  logic       Reset,
    ins_fetch_if.master bus
);

    // Highest word address that may be fetched.
    localparam logic [31:0] PC_LAST   = 32'(MEM_BYTES - 4);
    localparam logic [5:0]  OP_HALT   = 6'b111111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_VALID,
        S_HALTED,
        S_FAULT
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic        ir_valid_q;
    logic        halted_q;
    logic        fault_q;

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        target_ok;
    logic        is_halt;
    logic        accept;

    logic        do_capture;
    logic        do_advance;
    logic        do_halt;
    logic        do_fault;
    logic        ins_mem_rw;

    // Next-PC candidates; all arithmetic wraps modulo 2^32 before the range check.
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        next_pc  = pc_plus4;
        case (bus.PCSrc)
            2'b00: next_pc = pc_plus4;
            2'b01: next_pc = pc_plus4 + (bus.imm_ext << 2);
            2'b10: next_pc = bus.rs_data;
            2'b11: next_pc = {pc_plus4[31:28], ir_q[25:0], 2'b00};
            default: next_pc = pc_plus4;
        endcase
        target_ok = (next_pc[1:0] == 2'b00) && (next_pc <= PC_LAST);
    end

    assign is_halt = (ir_q[31:26] == OP_HALT);
    assign accept  = bus.dec_ready && bus.PCWre;

    // State register.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-edge datapath strobes.
    always_comb begin
        state_d    = state_q;
        do_capture = 1'b0;
        do_advance = 1'b0;
        do_halt    = 1'b0;
        do_fault   = 1'b0;
        ins_mem_rw = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // Memory read is combinational; Ins is valid at the closing edge.
                ins_mem_rw = 1'b1;
                do_capture = 1'b1;
                state_d    = S_VALID;
            end
            S_VALID: begin
                if (accept) begin
                    if (is_halt) begin
                        // Halt wins over any PCSrc selection.
                        do_halt = 1'b1;
                        state_d = S_HALTED;
                    end else if (target_ok) begin
                        do_advance = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        do_fault = 1'b1;
                        state_d  = S_FAULT;
                    end
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // pc, ir and the sticky status flags; pc only moves on a legal accepted target.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            pc_q       <= RESET_PC;
            ir_q       <= 32'h0000_0000;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            if (do_capture) begin
                ir_q       <= bus.Ins;
                ir_valid_q <= 1'b1;
            end
            if (do_advance) begin
                pc_q       <= next_pc;
                ir_valid_q <= 1'b0;
            end
            if (do_halt) begin
                ir_valid_q <= 1'b0;
                halted_q   <= 1'b1;
            end
            if (do_fault) begin
                ir_valid_q <= 1'b0;
                fault_q    <= 1'b1;
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt_q;

    // Count every instruction latched into ir; wraps naturally at 2^32.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            fetch_cnt_q <= 32'd0;
        end else if (do_capture) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign bus.fetch_count = fetch_cnt_q;
`else
    assign bus.fetch_count = 32'd0;
`endif

    assign bus.pc       = pc_q;
    assign bus.InsMemRW = ins_mem_rw;
    assign bus.ir       = ir_q;
    assign bus.ir_valid = ir_valid_q;
    assign bus.halted   = halted_q;
    assign bus.fault    = fault_q;

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: table of per-edge vectors plus hand sequences
// for jump/halt, out-of-range jr and asynchronous reset during FETCH.
module tb_ins_fetch;

    logic        CLK;
    logic        Reset;
    logic [31:0] mem [0:31];
    int          n_vec;
    int          n_err;

    ins_fetch_if bus ();

    ins_fetch #(
        .RESET_PC  (32'h0000_0000),
        .MEM_BYTES (128)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    assign bus.Ins = mem[bus.pc[6:2]];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        dr;
        logic        we;
        logic [1:0]  src;
        logic [31:0] imm;
        logic [31:0] rs;
        logic [31:0] pc;
        logic [31:0] ir;
        logic        irv;
        logic        rw;
        logic        hlt;
        logic        flt;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs [0:16];

    task automatic drive(input logic dr, input logic we, input logic [1:0] src,
                         input logic [31:0] imm, input logic [31:0] rs);
        bus.dec_ready = dr;
        bus.PCWre     = we;
        bus.PCSrc     = src;
        bus.imm_ext   = imm;
        bus.rs_data   = rs;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] epc, input logic [31:0] eir,
                         input logic eirv, input logic erw, input logic ehlt, input logic eflt,
                         input logic [31:0] ecnt);
        logic [31:0] cnt_exp;
`ifdef FETCH_STATS_EN
        cnt_exp = ecnt;
`else
        cnt_exp = 32'd0;
`endif
        n_vec++;
        if (bus.pc !== epc || bus.ir !== eir || bus.ir_valid !== eirv || bus.InsMemRW !== erw ||
            bus.halted !== ehlt || bus.fault !== eflt || bus.fetch_count !== cnt_exp) begin
            n_err++;
            $display("FAIL %s: got pc=%h ir=%h irv=%b rw=%b hlt=%b flt=%b cnt=%0d; want pc=%h ir=%h irv=%b rw=%b hlt=%b flt=%b cnt=%0d",
                     name, bus.pc, bus.ir, bus.ir_valid, bus.InsMemRW, bus.halted, bus.fault, bus.fetch_count,
                     epc, eir, eirv, erw, ehlt, eflt, cnt_exp);
        end
    endtask

    // Assert reset away from an edge, check the cleared state, release after the next edge.
    task automatic do_reset(input string name);
        Reset = 1'b0;
        #1;
        check(name, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(posedge CLK);
        #2;
        Reset = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0000_0000;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        Reset = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        clear_mem();
        mem[0] = 32'h0232_4020;
        mem[1] = 32'h0232_4022;
        mem[2] = 32'h0000_0020;

        //           dr    we    src    imm           rs            pc      ir             irv   rw    hlt   flt   cnt
        vecs[0]  = '{1'b1, 1'b1, 2'b00, 32'h0,        32'h0,        32'h0,  32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'd0}; // IDLE->FETCH
        vecs[1]  = '{1'b1, 1'b1, 2'b00, 32'h0,        32'h0,        32'h0,  32'h0232_4020, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1}; // capture word 0
        vecs[2]  = '{1'b1, 1'b1, 2'b00, 32'h0,        32'h0,        32'h4,  32'h0232_4020, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1}; // pc+4
        vecs[3]  = '{1'b1, 1'b1, 2'b00, 32'h0,        32'h0,        32'h4,  32'h0232_4022, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2}; // capture word 1
        vecs[4]  = '{1'b0, 1'b1, 2'b00, 32'h0,        32'h0,        32'h4,  32'h0232_4022, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2}; // decoder stall x5
        vecs[5]  = '{1'b0, 1'b1, 2'b00, 32'h0,        32'h0,        32'h4,  32'h0232_4022, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2};
        vecs[6]  = '{1'b0, 1'b1, 2'b00, 32'h0,        32'h0,        32'h4,  32'h0232_4022, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2};
        vecs[7]  = '{1'b0, 1'b1, 2'b00, 32'h0,        32'h0,        32'h4,  32'h0232_4022, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2};
        vecs[8]  = '{1'b0, 1'b1, 2'b00, 32'h0,        32'h0,        32'h4,  32'h0232_4022, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2};
        vecs[9]  = '{1'b1, 1'b0, 2'b00, 32'h0,        32'h0,        32'h4,  32'h0232_4022, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2}; // PCWre stall x2
        vecs[10] = '{1'b1, 1'b0, 2'b00, 32'h0,        32'h0,        32'h4,  32'h0232_4022, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2};
        vecs[11] = '{1'b1, 1'b1, 2'b00, 32'h0,        32'h0,        32'h8,  32'h0232_4022, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2}; // advance
        vecs[12] = '{1'b1, 1'b1, 2'b00, 32'h0,        32'h0,        32'h8,  32'h0000_0020, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3};
        vecs[13] = '{1'b1, 1'b1, 2'b01, 32'hFFFF_FFFE, 32'h0,       32'h4,  32'h0000_0020, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3}; // back branch 8->4
        vecs[14] = '{1'b1, 1'b1, 2'b00, 32'h0,        32'h0,        32'h4,  32'h0232_4022, 1'b1, 1'b0, 1'b0, 1'b0, 32'd4};
        vecs[15] = '{1'b1, 1'b1, 2'b10, 32'h0,        32'h82,       32'h4,  32'h0232_4022, 1'b0, 1'b0, 1'b0, 1'b1, 32'd4}; // jr misaligned
        vecs[16] = '{1'b1, 1'b1, 2'b00, 32'h0,        32'h0,        32'h4,  32'h0232_4022, 1'b0, 1'b0, 1'b0, 1'b1, 32'd4}; // FAULT terminal

        #12;
        check("reset_state", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        Reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].dr, vecs[i].we, vecs[i].src, vecs[i].imm, vecs[i].rs);
            step();
            check($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ir, vecs[i].irv, vecs[i].rw,
                  vecs[i].hlt, vecs[i].flt, vecs[i].cnt);
        end

        // Jump through ir then halt at the jump target.
        clear_mem();
        mem[1] = 32'h0800_0005;
        mem[5] = 32'hFC00_0000;
        drive(1'b1, 1'b1, 2'b00, 32'h0, 32'h0);
        do_reset("reset_from_fault");
        step(); check("jmp_e1", 32'h0,  32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        step(); check("jmp_e2", 32'h0,  32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'd1);
        step(); check("jmp_e3", 32'h4,  32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'd1);
        step(); check("jmp_e4", 32'h4,  32'h0800_0005, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2);
        drive(1'b1, 1'b1, 2'b11, 32'h0, 32'h0);
        step(); check("jump",   32'h14, 32'h0800_0005, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2);
        drive(1'b1, 1'b1, 2'b01, 32'h0000_0001, 32'h0);
        step(); check("hlt_cap", 32'h14, 32'hFC00_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3);
        step(); check("halt",    32'h14, 32'hFC00_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'd3);
        step(); check("halt_h1", 32'h14, 32'hFC00_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'd3);
        step(); check("halt_h2", 32'h14, 32'hFC00_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'd3);

        // jr to the first address past the end of memory.
        clear_mem();
        mem[0] = 32'h0232_4020;
        drive(1'b1, 1'b1, 2'b10, 32'h0, 32'h80);
        do_reset("reset_from_halt");
        step();
        step(); check("jr80_cap", 32'h0, 32'h0232_4020, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1);
        step(); check("jr80",     32'h0, 32'h0232_4020, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1);
        step(); check("jr80_h",   32'h0, 32'h0232_4020, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1);

        // Asynchronous reset in the middle of a FETCH cycle at pc=0x10.
        for (int i = 0; i < 8; i++) mem[i] = 32'h1000_0000 + 32'(i);
        drive(1'b1, 1'b1, 2'b00, 32'h0, 32'h0);
        do_reset("reset_from_fault2");
        for (int i = 0; i < 9; i++) step();
        check("pre_rst", 32'h10, 32'h1000_0003, 1'b0, 1'b1, 1'b0, 1'b0, 32'd4);
        #3;
        Reset = 1'b0;
        #1;
        check("async_rst", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge CLK);
        Reset = 1'b1;
        step(); check("rst_e1", 32'h0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        step(); check("rst_e2", 32'h0, 32'h1000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
